// File: rtl/any1_pkg.sv
// Shared ANY-1 types and constants: issue records, FU result records,
// opcode/func encodings and fault causes.
package any1_pkg;

  parameter int FU_QDEPTH = 4;

  // Major opcodes (7 bits)
  localparam logic [6:0] OP_R2    = 7'h02;
  localparam logic [6:0] OP_ADDI  = 7'h04;
  localparam logic [6:0] OP_SUBFI = 7'h05;
  localparam logic [6:0] OP_ANDI  = 7'h08;
  localparam logic [6:0] OP_ORI   = 7'h09;
  localparam logic [6:0] OP_XORI  = 7'h0A;
  localparam logic [6:0] OP_SEQI  = 7'h10;
  localparam logic [6:0] OP_SNEI  = 7'h11;
  localparam logic [6:0] OP_SLTI  = 7'h12;
  localparam logic [6:0] OP_SGTI  = 7'h13;
  localparam logic [6:0] OP_SLTUI = 7'h14;
  localparam logic [6:0] OP_SGTUI = 7'h15;

  // R2 function codes (6 bits)
  localparam logic [5:0] F_ADD  = 6'h04;
  localparam logic [5:0] F_SUB  = 6'h05;
  localparam logic [5:0] F_AND  = 6'h08;
  localparam logic [5:0] F_OR   = 6'h09;
  localparam logic [5:0] F_XOR  = 6'h0A;
  localparam logic [5:0] F_SEQ  = 6'h10;
  localparam logic [5:0] F_SNE  = 6'h11;
  localparam logic [5:0] F_SLT  = 6'h12;
  localparam logic [5:0] F_SGE  = 6'h13;
  localparam logic [5:0] F_SLTU = 6'h14;
  localparam logic [5:0] F_SGEU = 6'h15;
  localparam logic [5:0] F_MIN  = 6'h18;
  localparam logic [5:0] F_MAX  = 6'h19;

  // Fault causes
  localparam logic [7:0] FLT_NONE  = 8'h00;
  localparam logic [7:0] FLT_UNIMP = 8'h37;

  // R2-format instruction word
  typedef struct packed {
    logic [5:0] func;
    logic [5:0] rb;
    logic [5:0] ra;
    logic [5:0] rt;
    logic       sz;
    logic [6:0] opcode;
  } sInstR2;

  typedef union packed {
    logic [31:0] raw;
    sInstR2      r2;
  } sInstruction;

  // Issue record from the reorder/issue logic; wr is the write strobe
  typedef struct packed {
    logic        wr;
    logic [5:0]  rid;
    sInstruction ir;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] imm;
  } sALUrec;

  // Result record returned to the ROB; cmt is result-valid
  typedef struct packed {
    logic        cmt;
    logic [5:0]  rid;
    logic [5:0]  ele;
    logic [7:0]  cause;
    logic [63:0] badAddr;
    logic [63:0] res;
  } sFuncUnit;

endpackage

// File: rtl/any1_fu_fifo.sv
// Small synchronous FIFO of issue records shared by the ANY-1 functional
// units. Push is ignored when full, pop is ignored when empty, flush wins.
module any1_fu_fifo
  import any1_pkg::*;
#(
  parameter int DEPTH = FU_QDEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  sALUrec        rec_i,
  input  logic          pop_i,
  output sALUrec        head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  sALUrec        mem [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem[rptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Record storage; contents need no reset because count gates visibility
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q] <= rec_i;
  end

endmodule

// File: rtl/any1_alu_fu.sv
// ANY-1 integer ALU functional unit: buffers issue records, executes the
// head record combinationally and holds the result until the ROB acks it.
//
// Handshakes: an issue write (rec_i.wr) is accepted on a clock edge only
// when full_o is low and flush_i is low; a result is offered while fu_o.cmt
// is high and is consumed on any edge where ack_i is high.
module any1_alu_fu
  import any1_pkg::*;
#(
  parameter int QDEPTH = FU_QDEPTH
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     flush_i,
  input  sALUrec   rec_i,
  output logic     full_o,
  output logic     ovf_o,
  output sFuncUnit fu_o,
  input  logic     ack_i
);

  localparam int CW = $clog2(QDEPTH + 1);

  sALUrec        head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          res_free;

  logic [63:0]   op_a;
  logic [63:0]   op_b;
  logic          eq;
  logic          lt_s;
  logic          lt_u;
  logic [63:0]   exe_res;
  logic [7:0]    exe_cause;
  logic          unused_bits;

  assign push     = rec_i.wr & ~fifo_full & ~flush_i;
  assign res_free = ~fu_o.cmt | ack_i;
  assign pop      = (fifo_count != '0) & res_free & ~flush_i;
  assign full_o   = fifo_full;

  any1_fu_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .rec_i   (rec_i),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Instruction fields the ALU never decodes
  assign unused_bits = ^{head.wr, head.ir.r2.rb, head.ir.r2.ra,
                         head.ir.r2.rt, head.ir.r2.sz};

  // Occupancy and empty flag must always agree
  always_comb begin
    assert (fifo_empty == (fifo_count == '0));
  end

  // Operand selection: immediate forms replace b with the immediate
  assign op_a = head.a;
  assign op_b = (head.ir.r2.opcode == OP_R2) ? head.b : head.imm;
  assign eq   = (op_a == op_b);
  assign lt_s = ($signed(op_a) < $signed(op_b));
  assign lt_u = (op_a < op_b);

  // Execution mux on the FIFO head
  always_comb begin
    exe_res   = '0;
    exe_cause = FLT_NONE;
    case (head.ir.r2.opcode)
      OP_R2: begin
        case (head.ir.r2.func)
          F_ADD:   exe_res = op_a + op_b;
          F_SUB:   exe_res = op_a - op_b;
          F_AND:   exe_res = op_a & op_b;
          F_OR:    exe_res = op_a | op_b;
          F_XOR:   exe_res = op_a ^ op_b;
          F_SEQ:   exe_res = {63'd0, eq};
          F_SNE:   exe_res = {63'd0, ~eq};
          F_SLT:   exe_res = {63'd0, lt_s};
          F_SGE:   exe_res = {63'd0, ~lt_s};
          F_SLTU:  exe_res = {63'd0, lt_u};
          F_SGEU:  exe_res = {63'd0, ~lt_u};
          F_MIN:   exe_res = lt_s ? op_a : op_b;
          F_MAX:   exe_res = lt_s ? op_b : op_a;
          default: exe_cause = FLT_UNIMP;
        endcase
      end
      OP_ADDI:  exe_res = op_a + op_b;
      OP_SUBFI: exe_res = op_b - op_a;
      OP_ANDI:  exe_res = op_a & op_b;
      OP_ORI:   exe_res = op_a | op_b;
      OP_XORI:  exe_res = op_a ^ op_b;
      OP_SEQI:  exe_res = {63'd0, eq};
      OP_SNEI:  exe_res = {63'd0, ~eq};
      OP_SLTI:  exe_res = {63'd0, lt_s};
      OP_SGTI:  exe_res = {63'd0, ~lt_s & ~eq};
      OP_SLTUI: exe_res = {63'd0, lt_u};
      OP_SGTUI: exe_res = {63'd0, ~lt_u & ~eq};
      default:  exe_cause = FLT_UNIMP;
    endcase
  end

  // Sticky overflow: a write that arrives while full is dropped and flagged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_o <= 1'b0;
    end else if (!flush_i && rec_i.wr && fifo_full) begin
      ovf_o <= 1'b1;
    end
  end

  // Result register: loads on pop, drops cmt on ack, flush discards it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fu_o <= '0;
    end else if (flush_i) begin
      fu_o.cmt <= 1'b0;
    end else if (pop) begin
      fu_o.cmt     <= 1'b1;
      fu_o.rid     <= head.rid;
      fu_o.ele     <= 6'd0;
      fu_o.cause   <= exe_cause;
      fu_o.badAddr <= 64'd0;
      fu_o.res     <= exe_res;
    end else if (ack_i) begin
      fu_o.cmt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_any1_alu_fu.sv
// Testbench for any1_alu_fu: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_any1_alu_fu;
  import any1_pkg::*;

  localparam int QD = 4;

  logic     clk = 1'b0;
  logic     rst_ni = 1'b1;
  logic     flush_i = 1'b0;
  sALUrec   rec_i = '0;
  logic     full_o;
  logic     ovf_o;
  sFuncUnit fu_o;
  logic     ack_i = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  sALUrec      m_q[$];
  logic        m_cmt = 1'b0;
  logic [5:0]  m_rid = '0;
  logic [63:0] m_res = '0;
  logic [7:0]  m_cause = '0;
  logic        m_ovf = 1'b0;

  sALUrec idle_rec = '0;

  any1_alu_fu #(.QDEPTH(QD)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .rec_i   (rec_i),
    .full_o  (full_o),
    .ovf_o   (ovf_o),
    .fu_o    (fu_o),
    .ack_i   (ack_i)
  );

  // Clock
  always #5 clk = ~clk;

  // Architectural result of one ALU record, from the instruction definitions
  function automatic void model_exec(input sALUrec r, output logic [63:0] res,
                                     output logic [7:0] cause);
    longint sa, sb, si;
    logic [63:0] ua, ub, ui;
    ua = r.a; ub = r.b; ui = r.imm;
    sa = r.a; sb = r.b; si = r.imm;
    res = 64'd0;
    cause = FLT_NONE;
    if (r.ir.r2.opcode == OP_R2) begin
      case (r.ir.r2.func)
        F_ADD:   res = ua + ub;
        F_SUB:   res = ua - ub;
        F_AND:   res = ua & ub;
        F_OR:    res = ua | ub;
        F_XOR:   res = ua ^ ub;
        F_SEQ:   res = (ua == ub) ? 64'd1 : 64'd0;
        F_SNE:   res = (ua != ub) ? 64'd1 : 64'd0;
        F_SLT:   res = (sa < sb) ? 64'd1 : 64'd0;
        F_SGE:   res = (sa >= sb) ? 64'd1 : 64'd0;
        F_SLTU:  res = (ua < ub) ? 64'd1 : 64'd0;
        F_SGEU:  res = (ua >= ub) ? 64'd1 : 64'd0;
        F_MIN:   res = (sa <= sb) ? ua : ub;
        F_MAX:   res = (sa >= sb) ? ua : ub;
        default: cause = FLT_UNIMP;
      endcase
    end else begin
      case (r.ir.r2.opcode)
        OP_ADDI:  res = ua + ui;
        OP_SUBFI: res = ui - ua;
        OP_ANDI:  res = ua & ui;
        OP_ORI:   res = ua | ui;
        OP_XORI:  res = ua ^ ui;
        OP_SEQI:  res = (ua == ui) ? 64'd1 : 64'd0;
        OP_SNEI:  res = (ua != ui) ? 64'd1 : 64'd0;
        OP_SLTI:  res = (sa < si) ? 64'd1 : 64'd0;
        OP_SGTI:  res = (sa > si) ? 64'd1 : 64'd0;
        OP_SLTUI: res = (ua < ui) ? 64'd1 : 64'd0;
        OP_SGTUI: res = (ua > ui) ? 64'd1 : 64'd0;
        default:  cause = FLT_UNIMP;
      endcase
    end
  endfunction

  function automatic sALUrec make_rec(input logic [6:0] opc, input logic [5:0] fn,
                                      input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] imm, input logic [5:0] rid);
    sALUrec r;
    r = '0;
    r.ir.r2.opcode = opc;
    r.ir.r2.func = fn;
    r.a = a;
    r.b = b;
    r.imm = imm;
    r.rid = rid;
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'(int'($urandom_range(0, 15)));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Driver: apply one cycle of inputs, advance one edge, update the model
  task automatic tick(input logic wr, input sALUrec rec, input logic ack, input logic flush);
    bit was_full;
    sALUrec r;
    logic [63:0] res;
    logic [7:0] cause;
    rec_i = rec;
    rec_i.wr = wr;
    ack_i = ack;
    flush_i = flush;
    @(posedge clk);
    was_full = (m_q.size() == QD);
    if (flush) begin
      m_q.delete();
      m_cmt = 1'b0;
    end else begin
      if (m_q.size() > 0 && (!m_cmt || ack)) begin
        r = m_q.pop_front();
        model_exec(r, res, cause);
        m_cmt = 1'b1;
        m_rid = r.rid;
        m_res = res;
        m_cause = cause;
      end else if (ack) begin
        m_cmt = 1'b0;
      end
      if (wr) begin
        if (was_full) m_ovf = 1'b1;
        else m_q.push_back(rec);
      end
    end
    #1;
    rec_i.wr = 1'b0;
    ack_i = 1'b0;
    flush_i = 1'b0;
  endtask

  // Driver: issue one record, wait (bounded) for its result, then ack it
  task automatic run_one(input sALUrec r, output sFuncUnit got, output bit timed_out);
    timed_out = 1'b1;
    got = '0;
    tick(1'b1, r, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (fu_o.cmt) begin
        got = fu_o;
        timed_out = 1'b0;
        break;
      end
      tick(1'b0, idle_rec, 1'b0, 1'b0);
    end
    tick(1'b0, idle_rec, 1'b1, 1'b0);
  endtask

  // Driver: ack until unit and model are idle
  task automatic drain();
    for (int i = 0; i < 12; i++) begin
      if (!m_cmt && m_q.size() == 0) break;
      tick(1'b0, idle_rec, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (fu_o !== '0) begin errors++; $display("FAIL reset_fu got=%h exp=0", fu_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_o); end
    rst_ni = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    sALUrec r;
    r = make_rec(OP_R2, F_ADD, 64'd5, 64'd7, 64'd0, 6'd3);
    tick(1'b1, r, 1'b0, 1'b0);
    checks++; if (fu_o.cmt !== 1'b0) begin errors++; $display("FAIL add_early_cmt got=%b exp=0", fu_o.cmt); end
    tick(1'b0, idle_rec, 1'b0, 1'b0);
    checks++; if (fu_o.cmt !== 1'b1) begin errors++; $display("FAIL add_cmt got=%b exp=1", fu_o.cmt); end
    checks++; if (fu_o.res !== 64'd12) begin errors++; $display("FAIL add_res got=%0h exp=c", fu_o.res); end
    checks++; if (fu_o.rid !== 6'd3) begin errors++; $display("FAIL add_rid got=%0d exp=3", fu_o.rid); end
    checks++; if (fu_o.cause !== 8'h00) begin errors++; $display("FAIL add_cause got=%0h exp=0", fu_o.cause); end
    checks++; if (fu_o.ele !== 6'd0 || fu_o.badAddr !== 64'd0) begin errors++; $display("FAIL add_fixed ele=%0d badAddr=%0h exp=0,0", fu_o.ele, fu_o.badAddr); end
    tick(1'b0, idle_rec, 1'b0, 1'b0);
    checks++; if (fu_o.cmt !== 1'b1 || fu_o.res !== 64'd12) begin errors++; $display("FAIL add_hold cmt=%b res=%0h exp=1,c", fu_o.cmt, fu_o.res); end
    tick(1'b0, idle_rec, 1'b1, 1'b0);
    checks++; if (fu_o.cmt !== 1'b0) begin errors++; $display("FAIL add_ack got=%b exp=0", fu_o.cmt); end
  endtask

  task automatic test_compares();
    sFuncUnit got;
    bit to;
    run_one(make_rec(OP_R2, F_SLTU, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 6'd10), got, to);
    checks++; if (to || got.res !== 64'd1) begin errors++; $display("FAIL sltu timeout=%b got=%0h exp=1", to, got.res); end
    run_one(make_rec(OP_R2, F_SLT, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 6'd11), got, to);
    checks++; if (to || got.res !== 64'd0) begin errors++; $display("FAIL slt timeout=%b got=%0h exp=0", to, got.res); end
    run_one(make_rec(OP_SUBFI, 6'd0, 64'd10, 64'd0, 64'd3, 6'd12), got, to);
    checks++; if (to || got.res !== 64'hFFFF_FFFF_FFFF_FFF9) begin errors++; $display("FAIL subfi timeout=%b got=%0h exp=fffffffffffffff9", to, got.res); end
    run_one(make_rec(OP_R2, F_MIN, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'd0, 6'd13), got, to);
    checks++; if (to || got.res !== 64'hFFFF_FFFF_FFFF_FFFB) begin errors++; $display("FAIL min timeout=%b got=%0h exp=fffffffffffffffb", to, got.res); end
    run_one(make_rec(OP_R2, F_MAX, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'd0, 6'd14), got, to);
    checks++; if (to || got.res !== 64'd3) begin errors++; $display("FAIL max timeout=%b got=%0h exp=3", to, got.res); end
    run_one(make_rec(OP_SGTUI, 6'd0, 64'h8000_0000_0000_0000, 64'd0, 64'd1, 6'd15), got, to);
    checks++; if (to || got.res !== 64'd1) begin errors++; $display("FAIL sgtui timeout=%b got=%0h exp=1", to, got.res); end
  endtask

  task automatic test_unimp();
    sFuncUnit got;
    bit to;
    run_one(make_rec(OP_R2, 6'h3F, 64'd9, 64'd9, 64'd0, 6'd42), got, to);
    checks++; if (to || got.res !== 64'd0) begin errors++; $display("FAIL unimp_res timeout=%b got=%0h exp=0", to, got.res); end
    checks++; if (got.cause !== 8'h37) begin errors++; $display("FAIL unimp_cause got=%0h exp=37", got.cause); end
    checks++; if (got.rid !== 6'd42) begin errors++; $display("FAIL unimp_rid got=%0d exp=42", got.rid); end
    run_one(make_rec(7'h7F, 6'd0, 64'd1, 64'd1, 64'd1, 6'd43), got, to);
    checks++; if (to || got.cause !== 8'h37 || got.res !== 64'd0) begin errors++; $display("FAIL unimp_op timeout=%b cause=%0h res=%0h exp=37,0", to, got.cause, got.res); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] rids[3];
    rids[0] = 6'd21; rids[1] = 6'd22; rids[2] = 6'd23;
    tick(1'b1, make_rec(OP_ADDI, 6'd0, 64'd1, 64'd0, 64'd1, rids[0]), 1'b1, 1'b0);
    checks++; if (fu_o.cmt !== 1'b0) begin errors++; $display("FAIL b2b_lat got=%b exp=0", fu_o.cmt); end
    for (int i = 0; i < 3; i++) begin
      if (i < 2) tick(1'b1, make_rec(OP_ADDI, 6'd0, 64'd1, 64'd0, 64'd1, rids[i+1]), 1'b1, 1'b0);
      else tick(1'b0, idle_rec, 1'b1, 1'b0);
      checks++;
      if (fu_o.cmt !== 1'b1 || fu_o.rid !== rids[i]) begin
        errors++; $display("FAIL b2b_%0d cmt=%b rid=%0d exp=1,%0d", i, fu_o.cmt, fu_o.rid, rids[i]);
      end
    end
    tick(1'b0, idle_rec, 1'b1, 1'b0);
    checks++; if (fu_o.cmt !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", fu_o.cmt); end
  endtask

  task automatic test_flush();
    sFuncUnit got;
    bit to;
    for (int i = 0; i < 5; i++)
      tick(1'b1, make_rec(OP_R2, F_ADD, 64'(i), 64'd1, 64'd0, 6'(30 + i)), 1'b0, 1'b0);
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL flush_prefull got=%b exp=1", full_o); end
    tick(1'b1, make_rec(OP_R2, F_ADD, 64'd0, 64'd0, 64'd0, 6'd35), 1'b0, 1'b1);
    checks++; if (fu_o.cmt !== 1'b0) begin errors++; $display("FAIL flush_cmt got=%b exp=0", fu_o.cmt); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL flush_full got=%b exp=0", full_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL flush_ovf got=%b exp=0", ovf_o); end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, idle_rec, 1'b1, 1'b0);
      checks++; if (fu_o.cmt !== 1'b0) begin errors++; $display("FAIL flush_empty_%0d got=%b exp=0", i, fu_o.cmt); end
    end
    run_one(make_rec(OP_XORI, 6'd0, 64'hF0, 64'd0, 64'hFF, 6'd36), got, to);
    checks++; if (to || got.rid !== 6'd36 || got.res !== 64'h0F) begin errors++; $display("FAIL flush_after timeout=%b rid=%0d res=%0h exp=36,f", to, got.rid, got.res); end
  endtask

  task automatic test_overflow();
    logic [5:0] exp_q[$];
    for (int i = 1; i <= 5; i++) begin
      tick(1'b1, make_rec(OP_ORI, 6'd0, 64'd0, 64'd0, 64'(i), 6'(i)), 1'b0, 1'b0);
      exp_q.push_back(6'(i));
    end
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", full_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", ovf_o); end
    tick(1'b1, make_rec(OP_ORI, 6'd0, 64'd0, 64'd0, 64'd9, 6'd9), 1'b0, 1'b0);
    checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf_o); end
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL ovf_still_full got=%b exp=1", full_o); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (fu_o.cmt !== 1'b1 || fu_o.rid !== exp_q[i]) begin
        errors++; $display("FAIL ovf_order_%0d cmt=%b rid=%0d exp=1,%0d", i, fu_o.cmt, fu_o.rid, exp_q[i]);
      end
      tick(1'b0, idle_rec, 1'b1, 1'b0);
      if (i == 0) begin
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL ovf_full_drop got=%b exp=0", full_o); end
      end
    end
    checks++; if (fu_o.cmt !== 1'b0) begin errors++; $display("FAIL ovf_no_extra cmt=%b rid=%0d exp=0", fu_o.cmt, fu_o.rid); end
    checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf_o); end
  endtask

  task automatic test_random();
    logic [6:0] imm_ops[11];
    logic [5:0] funcs[13];
    logic [6:0] opc;
    logic [5:0] fn;
    sALUrec r;
    imm_ops = '{OP_ADDI, OP_SUBFI, OP_ANDI, OP_ORI, OP_XORI, OP_SEQI, OP_SNEI,
                OP_SLTI, OP_SGTI, OP_SLTUI, OP_SGTUI};
    funcs = '{F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SEQ, F_SNE, F_SLT, F_SGE,
              F_SLTU, F_SGEU, F_MIN, F_MAX};
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 9))
        0:       begin opc = 7'($urandom_range(0, 127)); fn = 6'($urandom_range(0, 63)); end
        1, 2, 3, 4: begin opc = OP_R2; fn = funcs[$urandom_range(0, 12)]; end
        default: begin opc = imm_ops[$urandom_range(0, 10)]; fn = 6'($urandom_range(0, 63)); end
      endcase
      r = make_rec(opc, fn, rand64(), rand64(), rand64(), 6'($urandom_range(0, 63)));
      tick($urandom_range(0, 99) < 60, r, $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
      checks++;
      if (full_o !== (m_q.size() == QD) || ovf_o !== m_ovf || fu_o.cmt !== m_cmt) begin
        errors++; $display("FAIL rand_ctl_%0d full=%b ovf=%b cmt=%b exp=%b,%b,%b", n, full_o, ovf_o,
                           fu_o.cmt, m_q.size() == QD, m_ovf, m_cmt);
      end
      if (m_cmt) begin
        checks++;
        if (fu_o.rid !== m_rid || fu_o.res !== m_res || fu_o.cause !== m_cause) begin
          errors++; $display("FAIL rand_res_%0d rid=%0d res=%h cause=%h exp=%0d,%h,%h", n, fu_o.rid,
                             fu_o.res, fu_o.cause, m_rid, m_res, m_cause);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    sFuncUnit got;
    bit to;
    for (int i = 0; i < 3; i++)
      tick(1'b1, make_rec(OP_R2, F_SUB, 64'd100, 64'(i), 64'd0, 6'(50 + i)), 1'b0, 1'b0);
    #3;
    rst_ni = 1'b0;
    #1;
    checks++; if (fu_o !== '0) begin errors++; $display("FAIL rstmid_fu got=%h exp=0", fu_o); end
    checks++; if (full_o !== 1'b0 || ovf_o !== 1'b0) begin errors++; $display("FAIL rstmid_flags full=%b ovf=%b exp=0,0", full_o, ovf_o); end
    m_q.delete();
    m_cmt = 1'b0;
    m_ovf = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    run_one(make_rec(OP_R2, F_ADD, 64'd5, 64'd7, 64'd0, 6'd3), got, to);
    checks++; if (to || got.res !== 64'd12 || got.rid !== 6'd3) begin errors++; $display("FAIL rstmid_after timeout=%b res=%0h rid=%0d exp=c,3", to, got.res, got.rid); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got=%b exp=0", ovf_o); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_compares();
    test_unimp();
    test_back_to_back();
    drain();
    test_flush();
    drain();
    test_overflow();
    drain();
    test_random();
    drain();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
